// File: rtl/ntt_pkg.sv
// ---------------------------------------------------------------------------
// ntt_pkg
// Shared constants and types for the NTT stream feeder slice.
//   N        : coefficients per polynomial
//   Q        : Kyber modulus, the upper bound for stored coefficients
//   TIMEOUT  : cycles the feeder waits in DRAIN for the first ntt_done
//   COEF_W   : coefficient width in bits
//   ADDR_W   : coefficient buffer address width
//   feeder_state_t : the four feeder FSM states
//   condSubQ : single conditional subtract used on the load path
// ---------------------------------------------------------------------------
package ntt_pkg;

    localparam int N       = 256;
    localparam int Q       = 3329;
    localparam int TIMEOUT = 160;
    localparam int COEF_W  = 12;
    localparam int ADDR_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREFETCH = 2'd1,
        ST_STREAM   = 2'd2,
        ST_DRAIN    = 2'd3
    } feeder_state_t;

    // One subtraction only: a 12-bit value is below 2*Q, so a single
    // conditional subtract always lands the value inside 0..Q-1.
    function automatic logic [COEF_W-1:0] condSubQ(
        input logic [COEF_W-1:0] value,
        input logic [COEF_W-1:0] modulus
    );
        return (value >= modulus) ? (value - modulus) : value;
    endfunction

endpackage

// File: rtl/coef_ram_2r1w.sv
// ---------------------------------------------------------------------------
// coef_ram_2r1w
// Coefficient buffer with one write port and two synchronous read ports.
// Read data appears one cycle after the address is presented. The array is
// never reset, so a reset leaves the loaded polynomial intact.
//   i_clk      : clock, rising edge
//   i_wrEn     : write strobe
//   i_wrAddr   : write address
//   i_wrData   : write data
//   i_rdAddr1  : read port 1 address (lower half during streaming)
//   i_rdAddr2  : read port 2 address (upper half during streaming)
//   o_rdData1  : registered read data for port 1
//   o_rdData2  : registered read data for port 2
// ---------------------------------------------------------------------------
module coef_ram_2r1w #(
    parameter int DEPTH  = ntt_pkg::N,
    parameter int ADDR_W = ntt_pkg::ADDR_W,
    parameter int DATA_W = ntt_pkg::COEF_W
) (
    input  logic              i_clk,
    input  logic              i_wrEn,
    input  logic [ADDR_W-1:0] i_wrAddr,
    input  logic [DATA_W-1:0] i_wrData,
    input  logic [ADDR_W-1:0] i_rdAddr1,
    input  logic [ADDR_W-1:0] i_rdAddr2,
    output logic [DATA_W-1:0] o_rdData1,
    output logic [DATA_W-1:0] o_rdData2
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Storage array plus both read registers. Keeping the write and the two
    // reads in one block lets synthesis map this onto a dual-read RAM; the
    // feeder never writes and reads in the same cycle, so read-during-write
    // ordering does not matter here.
    always_ff @(posedge i_clk) begin
        if (i_wrEn) begin
            r_mem[i_wrAddr] <= i_wrData;
        end
        o_rdData1 <= r_mem[i_rdAddr1];
        o_rdData2 <= r_mem[i_rdAddr2];
    end

endmodule

// File: rtl/ntt_stream_feeder.sv
// ---------------------------------------------------------------------------
// ntt_stream_feeder
// Holds one polynomial and streams it into a two-lane NTT pipeline as 128
// beats of (buffer[k], buffer[k+128]), then counts the pipeline's output
// beats and reports completion or one of several error conditions.
//   clk          : clock, rising edge
//   rst          : synchronous active-high reset
//   wr_en        : coefficient load strobe (honoured only in IDLE)
//   wr_addr      : coefficient index
//   wr_data      : coefficient value, reduced once by Q on the way in
//   start        : begin a transform (sampled only in IDLE)
//   mode_in      : 0 forward, 1 inverse; latched on start
//   busy         : high whenever the FSM is not in IDLE
//   ntt_mode     : latched mode driven to the pipeline
//   ntt_en       : beat valid to the pipeline
//   ntt_i1       : lane-1 coefficient
//   ntt_i2       : lane-2 coefficient
//   ntt_done     : output-valid from the pipeline
//   fin          : one-cycle pulse when all output beats were counted
//   range_err    : sticky, a loaded value was >= Q
//   timeout_err  : sticky, no ntt_done arrived in time
//   gap_err      : sticky, ntt_done dropped before all beats arrived
// ---------------------------------------------------------------------------
module ntt_stream_feeder #(
    parameter int N       = ntt_pkg::N,
    parameter int Q       = ntt_pkg::Q,
    parameter int TIMEOUT = ntt_pkg::TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [7:0]  wr_addr,
    input  logic [11:0] wr_data,
    input  logic        start,
    input  logic        mode_in,
    output logic        busy,
    output logic        ntt_mode,
    output logic        ntt_en,
    output logic [11:0] ntt_i1,
    output logic [11:0] ntt_i2,
    input  logic        ntt_done,
    output logic        fin,
    output logic        range_err,
    output logic        timeout_err,
    output logic        gap_err
);

    import ntt_pkg::*;

    localparam int                 HALF      = N / 2;
    localparam logic [7:0]         LAST_BEAT = 8'(HALF - 1);
    localparam int                 TO_W      = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0]    TO_LAST   = TO_W'(TIMEOUT - 1);
    localparam logic [COEF_W-1:0]  Q_W       = COEF_W'(Q);

    feeder_state_t     r_state;
    logic [6:0]        r_rdIdx;
    logic [7:0]        r_beatCnt;
    logic [7:0]        r_doneCnt;
    logic              r_doneSeen;
    logic [TO_W-1:0]   r_toCnt;
    logic              r_nttMode;
    logic              r_nttEn;
    logic [11:0]       r_nttI1;
    logic [11:0]       r_nttI2;
    logic              r_fin;
    logic              r_rangeErr;
    logic              r_timeoutErr;
    logic              r_gapErr;

    logic              w_wrEn;
    logic [11:0]       w_wrData;
    logic              w_rangeHit;
    logic [7:0]        w_rdAddr1;
    logic [7:0]        w_rdAddr2;
    logic [11:0]       w_rdData1;
    logic [11:0]       w_rdData2;
    logic              w_tracking;

    // Load path: writes are accepted only while idle so a running transform
    // always sees a stable polynomial. Out-of-range values are folded back
    // into 0..Q-1 with one subtract and flagged below in the FSM.
    assign w_wrEn     = wr_en && (r_state == ST_IDLE);
    assign w_wrData   = condSubQ(wr_data, Q_W);
    assign w_rangeHit = (wr_data >= Q_W);

    // Both lanes share one read index; the top address bit selects the
    // lower or upper half of the polynomial.
    assign w_rdAddr1  = {1'b0, r_rdIdx};
    assign w_rdAddr2  = {1'b1, r_rdIdx};

    // Output beats from the pipeline can start arriving while we are still
    // streaming (its latency is shorter than the 128-beat burst), so done
    // tracking runs in STREAM as well as DRAIN.
    assign w_tracking = (r_state == ST_STREAM) || (r_state == ST_DRAIN);

    coef_ram_2r1w #(
        .DEPTH  (256),
        .ADDR_W (8),
        .DATA_W (12)
    ) u_coefRam (
        .i_clk     (clk),
        .i_wrEn    (w_wrEn),
        .i_wrAddr  (wr_addr),
        .i_wrData  (w_wrData),
        .i_rdAddr1 (w_rdAddr1),
        .i_rdAddr2 (w_rdAddr2),
        .o_rdData1 (w_rdData1),
        .o_rdData2 (w_rdData2)
    );

    // Feeder state machine with all outputs registered.
    // The read for beat k is issued at the edge that leaves PREFETCH (k = 0)
    // or at the k-th STREAM edge; the RAM returns it one cycle later and the
    // next STREAM edge moves it into ntt_i1/ntt_i2. That gives beat k valid
    // after edge t+2+k when start was sampled at edge t.
    // Beat outputs default to zero every cycle so nothing leaks onto the
    // lanes outside STREAM. The done-tracking section sits after the case
    // statement so that a fin/gap/timeout exit overrides the normal
    // per-state assignments in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_rdIdx      <= '0;
            r_beatCnt    <= '0;
            r_doneCnt    <= '0;
            r_doneSeen   <= 1'b0;
            r_toCnt      <= '0;
            r_nttMode    <= 1'b0;
            r_nttEn      <= 1'b0;
            r_nttI1      <= '0;
            r_nttI2      <= '0;
            r_fin        <= 1'b0;
            r_rangeErr   <= 1'b0;
            r_timeoutErr <= 1'b0;
            r_gapErr     <= 1'b0;
        end else begin
            r_fin   <= 1'b0;
            r_nttEn <= 1'b0;
            r_nttI1 <= '0;
            r_nttI2 <= '0;

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state      <= ST_PREFETCH;
                        r_nttMode    <= mode_in;
                        r_rdIdx      <= '0;
                        r_beatCnt    <= '0;
                        r_doneCnt    <= '0;
                        r_doneSeen   <= 1'b0;
                        r_toCnt      <= '0;
                        r_rangeErr   <= 1'b0;
                        r_timeoutErr <= 1'b0;
                        r_gapErr     <= 1'b0;
                    end
                    // A write in the same cycle as start still flags, so
                    // this comes after the clear.
                    if (wr_en && w_rangeHit) begin
                        r_rangeErr <= 1'b1;
                    end
                end

                ST_PREFETCH: begin
                    r_rdIdx <= r_rdIdx + 7'd1;
                    r_state <= ST_STREAM;
                end

                ST_STREAM: begin
                    r_nttEn   <= 1'b1;
                    r_nttI1   <= w_rdData1;
                    r_nttI2   <= w_rdData2;
                    r_rdIdx   <= r_rdIdx + 7'd1;
                    r_beatCnt <= r_beatCnt + 8'd1;
                    if (r_beatCnt == LAST_BEAT) begin
                        r_state <= ST_DRAIN;
                        r_toCnt <= '0;
                    end
                end

                ST_DRAIN: begin
                    r_state <= ST_DRAIN;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            if (w_tracking) begin
                if (ntt_done) begin
                    r_doneSeen <= 1'b1;
                    r_doneCnt  <= r_doneCnt + 8'd1;
                    if (r_doneCnt == LAST_BEAT) begin
                        r_fin   <= 1'b1;
                        r_state <= ST_IDLE;
                        r_nttEn <= 1'b0;
                        r_nttI1 <= '0;
                        r_nttI2 <= '0;
                    end
                end else if (r_doneSeen) begin
                    r_gapErr <= 1'b1;
                    r_state  <= ST_IDLE;
                    r_nttEn  <= 1'b0;
                    r_nttI1  <= '0;
                    r_nttI2  <= '0;
                end else if (r_state == ST_DRAIN) begin
                    if (r_toCnt == TO_LAST) begin
                        r_timeoutErr <= 1'b1;
                        r_state      <= ST_IDLE;
                    end else begin
                        r_toCnt <= r_toCnt + TO_W'(1);
                    end
                end
            end
        end
    end

    // Output mapping; busy is a straight decode of the state register.
    assign busy        = (r_state != ST_IDLE);
    assign ntt_mode    = r_nttMode;
    assign ntt_en      = r_nttEn;
    assign ntt_i1      = r_nttI1;
    assign ntt_i2      = r_nttI2;
    assign fin         = r_fin;
    assign range_err   = r_rangeErr;
    assign timeout_err = r_timeoutErr;
    assign gap_err     = r_gapErr;

endmodule

// File: tb/tb_ntt_stream_feeder.sv
// ---------------------------------------------------------------------------
// tb_ntt_stream_feeder
// Directed bench for ntt_stream_feeder. A small pipeline stand-in replays
// ntt_en as ntt_done after a configurable latency, optionally cutting off
// after a fixed number of beats. Expected coefficients come from a bench
// copy of the buffer filled with hand-computed values.
// ---------------------------------------------------------------------------
module tb_ntt_stream_feeder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [7:0]  wr_addr = '0;
    logic [11:0] wr_data = '0;
    logic        start = 1'b0;
    logic        mode_in = 1'b0;
    logic        busy;
    logic        ntt_mode;
    logic        ntt_en;
    logic [11:0] ntt_i1;
    logic [11:0] ntt_i2;
    logic        ntt_done = 1'b0;
    logic        fin;
    logic        range_err;
    logic        timeout_err;
    logic        gap_err;

    int compareCount  = 0;
    int mismatchCount = 0;

    int model [256];

    // Pipeline stand-in configuration (written by the main sequence) and
    // its private beat counter (written only by the stand-in).
    bit histEn [1024];
    int modelCyc  = 0;
    int doneLat   = 111;
    bit doneEn    = 1'b0;
    int doneLimit = 32'h7fff_ffff;
    int doneGiven = 0;

    // Observation results of the most recent run.
    int          obsFirstEn, obsEnLast, obsBeat, obsIdleNz, obsModeBad;
    int          obsFin, obsFinCycle, obsBusyFall, obsRestart;
    int          obsToCycle, obsGapCycle;
    logic        snapRange, snapEn, snapBusy;
    logic [11:0] snapI1, snapI2;

    always #5 clk = ~clk;

    ntt_stream_feeder #(
        .N       (256),
        .Q       (3329),
        .TIMEOUT (160)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .start       (start),
        .mode_in     (mode_in),
        .busy        (busy),
        .ntt_mode    (ntt_mode),
        .ntt_en      (ntt_en),
        .ntt_i1      (ntt_i1),
        .ntt_i2      (ntt_i2),
        .ntt_done    (ntt_done),
        .fin         (fin),
        .range_err   (range_err),
        .timeout_err (timeout_err),
        .gap_err     (gap_err)
    );

    // Pipeline stand-in: ntt_en seen after edge p becomes ntt_done after
    // edge p+doneLat, limited to doneLimit beats in total.
    always @(negedge clk) begin
        histEn[modelCyc % 1024] = (ntt_en === 1'b1);
        if (doneEn && (modelCyc >= doneLat) &&
            histEn[(modelCyc - doneLat) % 1024] && (doneGiven < doneLimit)) begin
            ntt_done  = 1'b1;
            doneGiven = doneGiven + 1;
        end else begin
            ntt_done = 1'b0;
        end
        modelCyc = modelCyc + 1;
    end

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount = compareCount + 1;
        if (observed !== expected) begin
            mismatchCount = mismatchCount + 1;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // One load cycle.
    task automatic writeCoef(input int addr, input int data);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = 8'(addr);
        wr_data = 12'(data);
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    // Pulse start so it is sampled at edge t; returns at the negedge after t.
    task automatic applyStimulus(input logic mode);
        @(negedge clk);
        start   = 1'b1;
        mode_in = mode;
        @(negedge clk);
        start   = 1'b0;
    endtask

    // Watch maxCycles cycles after the start edge; cycle c is sampled after
    // edge t+c. Optionally pulses start at cycle startBusyCycle (sampled at
    // edge t+c+1) and holds reset for the edge after rstCycle.
    task automatic observe(input int maxCycles, input logic expMode,
                           input int startBusyCycle, input int rstCycle);
        obsFirstEn = -1; obsEnLast = -1; obsBeat = 0; obsIdleNz = 0;
        obsModeBad = 0; obsFin = 0; obsFinCycle = -1; obsBusyFall = -1;
        obsRestart = 0; obsToCycle = -1; obsGapCycle = -1;
        snapRange = 1'bx; snapEn = 1'bx; snapBusy = 1'bx;
        snapI1 = 'x; snapI2 = 'x;
        for (int c = 1; c <= maxCycles; c++) begin
            @(negedge clk);
            if (ntt_en === 1'b1) begin
                if (obsFirstEn < 0) obsFirstEn = c;
                obsEnLast = c;
                if (obsBeat < 128) begin
                    checkOutput($sformatf("lane1 beat %0d", obsBeat), 32'(ntt_i1), model[obsBeat]);
                    checkOutput($sformatf("lane2 beat %0d", obsBeat), 32'(ntt_i2), model[obsBeat + 128]);
                end
                obsBeat = obsBeat + 1;
            end else if (ntt_i1 != 12'd0 || ntt_i2 != 12'd0) begin
                obsIdleNz = obsIdleNz + 1;
            end
            if (busy === 1'b1 && ntt_mode !== expMode) obsModeBad = obsModeBad + 1;
            if (fin === 1'b1) begin
                obsFin = obsFin + 1;
                obsFinCycle = c;
            end
            if (busy === 1'b1 && obsBusyFall >= 0) obsRestart = obsRestart + 1;
            if (busy !== 1'b1 && obsBusyFall < 0) obsBusyFall = c;
            if (timeout_err === 1'b1 && obsToCycle < 0) obsToCycle = c;
            if (gap_err === 1'b1 && obsGapCycle < 0) obsGapCycle = c;
            if (c == 1) snapRange = range_err;
            if (c == rstCycle + 1) begin
                snapEn   = ntt_en;
                snapBusy = busy;
                snapI1   = ntt_i1;
                snapI2   = ntt_i2;
            end
            if (c == startBusyCycle) begin
                start   = 1'b1;
                mode_in = 1'b1;
            end else begin
                start = 1'b0;
            end
            rst = (c == rstCycle);
        end
        start = 1'b0;
        rst   = 1'b0;
    endtask

    initial begin
        $display("[TB] ntt_stream_feeder directed bench");

        // Reset values.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset busy", 32'(busy), 0);
        checkOutput("reset ntt_en", 32'(ntt_en), 0);
        checkOutput("reset ntt_mode", 32'(ntt_mode), 0);
        checkOutput("reset ntt_i1", 32'(ntt_i1), 0);
        checkOutput("reset ntt_i2", 32'(ntt_i2), 0);
        checkOutput("reset fin", 32'(fin), 0);
        checkOutput("reset range_err", 32'(range_err), 0);
        checkOutput("reset timeout_err", 32'(timeout_err), 0);
        checkOutput("reset gap_err", 32'(gap_err), 0);
        rst = 1'b0;

        // Ramp load and forward transform, pipeline latency 111.
        for (int a = 0; a < 256; a++) begin
            writeCoef(a, a);
            model[a] = a;
        end
        checkOutput("ramp load range_err", 32'(range_err), 0);
        doneLat = 111; doneLimit = 32'h7fff_ffff; doneEn = 1'b1;
        applyStimulus(1'b0);
        observe(260, 1'b0, -1, -1);
        checkOutput("ramp first beat cycle", obsFirstEn, 2);
        checkOutput("ramp last beat cycle", obsEnLast, 129);
        checkOutput("ramp beat count", obsBeat, 128);
        checkOutput("ramp lanes zero outside stream", obsIdleNz, 0);
        checkOutput("ramp mode held", obsModeBad, 0);
        checkOutput("ramp fin count", obsFin, 1);
        checkOutput("ramp fin cycle", obsFinCycle, 241);
        checkOutput("ramp busy fall cycle", obsBusyFall, 241);
        checkOutput("ramp no restart", obsRestart, 0);

        // Inverse transform, latency 117, start arriving on the fin edge.
        doneLat = 117;
        applyStimulus(1'b1);
        observe(260, 1'b1, 246, -1);
        checkOutput("inverse beat count", obsBeat, 128);
        checkOutput("inverse mode held", obsModeBad, 0);
        checkOutput("inverse fin count", obsFin, 1);
        checkOutput("inverse fin cycle", obsFinCycle, 247);
        checkOutput("inverse start on fin ignored", obsRestart, 0);
        checkOutput("inverse timeout_err", 32'(timeout_err), 0);
        checkOutput("inverse gap_err", 32'(gap_err), 0);
        checkOutput("inverse range_err", 32'(range_err), 0);

        // Range folding on load.
        writeCoef(128, 3328);
        checkOutput("range 3328 no flag", 32'(range_err), 0);
        writeCoef(0, 3329);
        checkOutput("range 3329 flag", 32'(range_err), 1);
        writeCoef(1, 4095);
        checkOutput("range 4095 flag", 32'(range_err), 1);
        model[0]   = 0;
        model[1]   = 766;
        model[128] = 3328;
        doneLat = 111;
        applyStimulus(1'b0);
        observe(260, 1'b0, -1, -1);
        checkOutput("range flag cleared by start", 32'(snapRange), 0);
        checkOutput("range beat count", obsBeat, 128);
        checkOutput("range fin count", obsFin, 1);

        // Timeout: pipeline never answers.
        doneEn = 1'b0;
        applyStimulus(1'b0);
        observe(300, 1'b0, -1, -1);
        checkOutput("timeout flag cycle", obsToCycle, 289);
        checkOutput("timeout busy fall cycle", obsBusyFall, 289);
        checkOutput("timeout fin count", obsFin, 0);
        checkOutput("timeout gap_err", obsGapCycle, -1);

        // Gap: pipeline stops after 50 beats.
        doneLat = 111; doneLimit = doneGiven + 50; doneEn = 1'b1;
        applyStimulus(1'b0);
        observe(200, 1'b0, -1, -1);
        checkOutput("gap flag cycle", obsGapCycle, 164);
        checkOutput("gap busy fall cycle", obsBusyFall, 164);
        checkOutput("gap fin count", obsFin, 0);
        checkOutput("gap timeout flag cleared", obsToCycle, -1);

        // Reset just before beat 60 would appear.
        doneEn = 1'b0; doneLimit = 32'h7fff_ffff;
        applyStimulus(1'b0);
        observe(200, 1'b0, -1, 61);
        checkOutput("midreset beats before reset", obsBeat, 60);
        checkOutput("midreset ntt_en", 32'(snapEn), 0);
        checkOutput("midreset busy", 32'(snapBusy), 0);
        checkOutput("midreset ntt_i1", 32'(snapI1), 0);
        checkOutput("midreset ntt_i2", 32'(snapI2), 0);
        checkOutput("midreset gap_err", 32'(gap_err), 0);

        // Replay of the untouched buffer, with a start pulse while busy.
        doneLat = 111; doneEn = 1'b1;
        applyStimulus(1'b0);
        observe(260, 1'b0, 50, -1);
        checkOutput("replay first beat cycle", obsFirstEn, 2);
        checkOutput("replay beat count", obsBeat, 128);
        checkOutput("replay mode held", obsModeBad, 0);
        checkOutput("replay fin count", obsFin, 1);
        checkOutput("replay fin cycle", obsFinCycle, 241);
        checkOutput("replay busy start ignored", obsRestart, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/ntt_stream_feeder.md
NTT_STREAM_FEEDER -- requirements
Module: ntt_stream_feeder

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- N, 256: coefficients per polynomial.
- Q, 3329: Kyber modulus.
- TIMEOUT, 160: maximum cycles from the last issued beat to the first ntt_done.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1: single clock; all logic on the rising edge.
- rst, in, 1: reset, synchronous and active-high.
- wr_en, in, 1: coefficient load strobe.
- wr_addr, in, 8: coefficient index, 0..255.
- wr_data, in, 12: coefficient value.
- start, in, 1: begin a transform; sampled only in IDLE.
- mode_in, in, 1: 0 = forward NTT, 1 = inverse NTT.
- busy, out, 1: high in any state other than IDLE.
- ntt_mode, out, 1: mode driven to the NTT pipeline.
- ntt_en, out, 1: beat valid to the NTT pipeline.
- ntt_i1, out, 12: lane-1 coefficient.
- ntt_i2, out, 12: lane-2 coefficient.
- ntt_done, in, 1: output-valid from the NTT pipeline.
- fin, out, 1: one-cycle pulse when 128 output beats have been counted.
- range_err, out, 1: sticky flag; a loaded value was >= Q.
- timeout_err, out, 1: sticky flag; ntt_done never arrived.
- gap_err, out, 1: sticky flag; ntt_done dropped early.

Function
REQ-003 The block SHALL hold a 256 x 12 coefficient buffer.
- In IDLE, wr_en writes wr_data to buffer[wr_addr].
- When busy, wr_en is ignored.
REQ-004 Loading rule: wr_data >= Q SHALL store wr_data - Q and set range_err; the store is a single conditional subtract.
REQ-005 The state machine SHALL have exactly four states: IDLE, PREFETCH, STREAM, DRAIN.
REQ-006 IDLE -> PREFETCH on start = 1; mode_in is latched into ntt_mode at that edge.
REQ-007 ntt_mode SHALL hold its latched value until the return to IDLE.
REQ-008 PREFETCH SHALL last one cycle; it issues the buffer read for beat 0.
REQ-009 STREAM SHALL hold ntt_en = 1 for exactly 128 consecutive cycles, beats k = 0..127.
- ntt_i1 = buffer[k], ntt_i2 = buffer[k+128].
- ntt_en, ntt_i1 and ntt_i2 are registered outputs.
REQ-010 Timing: if start is sampled at edge t, beat k SHALL be valid after edge t+2+k.
REQ-011 Outside STREAM, ntt_en SHALL be 0 and ntt_i1/ntt_i2 SHALL be 0.
REQ-012 STREAM -> DRAIN after beat 127; a cycle counter is then cleared.
REQ-013 DRAIN SHALL count beats where ntt_done = 1.
- The 128th counted beat pulses fin for one cycle and returns the FSM to IDLE.
REQ-014 If no ntt_done arrives within TIMEOUT cycles of entering DRAIN, the block SHALL set timeout_err and return to IDLE without asserting fin.
REQ-015 If ntt_done falls after the first done beat but before 128 beats are counted, the block SHALL set gap_err and return to IDLE without fin.
REQ-016 start asserted while busy SHALL be ignored; it is not queued.
REQ-017 Error flags SHALL clear only on reset, or on the edge where a new start is accepted.
REQ-018 fin and a new start in the same cycle: fin completes first; start is honored only once the FSM is in IDLE on a later cycle.

Reset
REQ-019 With rst = 1 at an edge, the block SHALL enter IDLE regardless of current state. Output values:
- busy = 0, ntt_en = 0, ntt_mode = 0;
- ntt_i1 = 0, ntt_i2 = 0;
- fin = 0, all error flags = 0;
- all counters = 0.
REQ-020 Reset SHALL NOT clear buffer contents.
REQ-021 A reset mid-STREAM SHALL drop ntt_en to 0 at that same edge.

Structure
REQ-022 N, Q, TIMEOUT and the state encoding SHALL live in a shared package, ntt_pkg.
REQ-023 The coefficient buffer SHALL be one sub-module, coef_ram_2r1w.
- Two synchronous read ports, addresses k and k+128.
- One write port.
- One-cycle read latency.

Verification
REQ-024 The bench SHALL cover the following directed scenarios:
- Ramp: load buffer[a] = a, start with mode_in = 0 -> 128 beats with ntt_i1 = k and ntt_i2 = k+128, first beat 2 cycles after start; ntt_done model at latency 111 -> fin pulses once and busy falls.
- Inverse mode: mode_in = 1 with the done model at latency 117 -> ntt_mode = 1 throughout, fin pulses, no error flags set.
- Range: write 3329, 4095 and 3328 -> stored values 0, 766 and 3328; range_err = 1.
- Timeout: start, never assert ntt_done -> timeout_err = 1 exactly 160 cycles after DRAIN entry, fin never asserted.
- Gap: ntt_done drops after 50 beats -> gap_err = 1, FSM in IDLE.
- Reset at beat 60 -> ntt_en = 0 after that edge; a subsequent start replays the unchanged buffer correctly; a start while busy has no effect.
